// File: rtl/onehot_encoder_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_encoder_reg_if
//  Purpose  : Handshake bus for the registered 2^N-to-N priority encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface onehot_encoder_reg_if #(
   parameter int N    = 3,
   parameter int ERRW = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [(1<<N)-1:0]    a;
   logic                 out_valid;
   logic                 out_ready;
   logic [N-1:0]         y;
   logic                 multi;
   logic                 none;
   logic [ERRW-1:0]      err_count;
   logic                 clr_err;

   modport master (
      output in_valid, a, out_ready, clr_err,
      input  in_ready, out_valid, y, multi, none, err_count
   );

   modport slave (
      input  in_valid, a, out_ready, clr_err,
      output in_ready, out_valid, y, multi, none, err_count
   );
endinterface
`default_nettype wire

// File: rtl/onehot_encoder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_encoder_reg
//  Purpose  : Registered priority encoder (highest set bit) with error flags
//             and a saturating error counter, valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_encoder_reg #(
   parameter int N    = 3,
   parameter int ERRW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   onehot_encoder_reg_if.slave  bus
);
   localparam int              c_W       = 1 << N;
   localparam logic [ERRW-1:0] c_ERR_MAX = {ERRW{1'b1}};

   logic              r_valid;
   logic [N-1:0]      r_y;
   logic              r_multi;
   logic              r_none;
   logic [ERRW-1:0]   r_err;

   logic              w_ready;
   logic              w_accept;
   logic [N-1:0]      w_idx;
   logic              w_multi;
   logic              w_none;

   assign w_ready  = !r_valid || bus.out_ready;
   assign w_accept = bus.in_valid && w_ready;

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < c_W; i++) begin
         if (bus.a[i]) w_idx = i[N-1:0];
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_multi = |(bus.a & (bus.a - 1'b1));
   assign w_none  = (bus.a == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_y     <= '0;
         r_multi <= 1'b0;
         r_none  <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_y     <= w_idx;
         r_multi <= w_multi;
         r_none  <= w_none;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= '0;
      end else if (bus.clr_err) begin
         r_err <= '0;
      end else if (w_accept && (w_multi || w_none) && (r_err != c_ERR_MAX)) begin
         r_err <= r_err + 1'b1;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_valid;
   assign bus.y         = r_y;
   assign bus.multi     = r_multi;
   assign bus.none      = r_none;
   assign bus.err_count = r_err;
endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_encoder_reg
//  Purpose  : Self-checking bench: vector table, corner sequences and random
//             traffic against a behavioural model (ERRW=8 and ERRW=2 copies).
//  Revision : 1.0  initial release
// ============================================================================
module tb_onehot_encoder_reg;
   logic clk;
   logic reset;

   onehot_encoder_reg_if #(.N(3), .ERRW(8)) bus8 ();
   onehot_encoder_reg_if #(.N(3), .ERRW(2)) bus2 ();

   assign bus2.in_valid  = bus8.in_valid;
   assign bus2.a         = bus8.a;
   assign bus2.out_ready = bus8.out_ready;
   assign bus2.clr_err   = bus8.clr_err;

   onehot_encoder_reg #(.N(3), .ERRW(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
   onehot_encoder_reg #(.N(3), .ERRW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit m_valid;
   int m_y;
   bit m_multi;
   bit m_none;
   int m_err8;
   int m_err2;

   typedef struct {
      bit        v;
      bit [7:0]  a;
      bit        ordy;
      bit        exp_valid;
      int        exp_y;
      bit        exp_multi;
      bit        exp_none;
   } vec_t;

   vec_t vt[13];

   task automatic check(input string nm, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
   endtask

   function automatic int hi_index(input bit [7:0] v);
      int x = int'(v);
      int r = 0;
      while (x > 1) begin
         x = x / 2;
         r++;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_y = 0; m_multi = 0; m_none = 0; m_err8 = 0; m_err2 = 0;
   endtask

   // One clock: drive inputs, check in_ready, advance model, check registered outputs.
   task automatic cycle(input bit v, input bit [7:0] aa, input bit ordy, input bit clr);
      bit acc;
      bit bad;
      bus8.in_valid  = v;
      bus8.a         = aa;
      bus8.out_ready = ordy;
      bus8.clr_err   = clr;
      #1;
      check("in_ready", int'(bus8.in_ready), int'(!m_valid || ordy));
      acc = v && (!m_valid || ordy);
      bad = ($countones(aa) != 1);
      if (acc) begin
         m_valid = 1;
         m_y     = (aa == 0) ? 0 : hi_index(aa);
         m_multi = ($countones(aa) >= 2);
         m_none  = (aa == 0);
      end else if (m_valid && ordy) begin
         m_valid = 0;
      end
      if (clr) begin
         m_err8 = 0;
         m_err2 = 0;
      end else if (acc && bad) begin
         if (m_err8 < 255) m_err8++;
         if (m_err2 < 3)   m_err2++;
      end
      @(posedge clk);
      #1;
      check("out_valid", int'(bus8.out_valid), int'(m_valid));
      check("err_count8", int'(bus8.err_count), m_err8);
      check("err_count2", int'(bus2.err_count), m_err2);
      if (m_valid) begin
         check("y", int'(bus8.y), m_y);
         check("multi", int'(bus8.multi), int'(m_multi));
         check("none", int'(bus8.none), int'(m_none));
         check("y_w2", int'(bus2.y), m_y);
      end
   endtask

   initial begin
      bit [7:0] ra;
      bit [7:0] dec;

      for (int i = 0; i < 8; i++)
         vt[i] = '{1'b1, 8'(1 << i), 1'b1, 1'b1, i, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 8'hA0, 1'b1, 1'b1, 7, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1};
      vt[10] = '{1'b1, 8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b0};
      vt[11] = '{1'b1, 8'hFF, 1'b1, 1'b1, 7, 1'b1, 1'b0};
      vt[12] = '{1'b0, 8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b0};

      // Reset held with a word offered: nothing may be accepted.
      model_reset();
      reset          = 1'b1;
      bus8.in_valid  = 1'b1;
      bus8.a         = 8'b0000_0100;
      bus8.out_ready = 1'b1;
      bus8.clr_err   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(bus8.out_valid), 0);
      check("rst_err_count", int'(bus8.err_count), 0);
      check("rst_y", int'(bus8.y), 0);
      check("rst_multi", int'(bus8.multi), 0);
      check("rst_none", int'(bus8.none), 0);
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, 8'b0000_0100, 1'b1, 1'b0);
      check("first_y", int'(bus8.y), 2);

      for (int i = 0; i < 13; i++) begin
         cycle(vt[i].v, vt[i].a, vt[i].ordy, 1'b0);
         check("tbl_valid", int'(bus8.out_valid), int'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            check("tbl_y", int'(bus8.y), vt[i].exp_y);
            check("tbl_multi", int'(bus8.multi), int'(vt[i].exp_multi));
            check("tbl_none", int'(bus8.none), int'(vt[i].exp_none));
         end
         if (i < 8) begin
            check("sweep_err", int'(bus8.err_count), 0);
            dec = 8'(1 << bus8.y);
            check("decode_inverse", int'(dec), int'(vt[i].a));
         end
         if (i == 9) check("err_after_two", int'(bus8.err_count), 2);
      end

      // Backpressure: held result survives, stalled word enters on release without a bubble.
      cycle(1'b1, 8'h10, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 8'h01, 1'b0, 1'b0);
         check("stall_y", int'(bus8.y), 4);
         check("stall_ready", int'(bus8.in_ready), 0);
      end
      cycle(1'b1, 8'h01, 1'b1, 1'b0);
      check("unstall_valid", int'(bus8.out_valid), 1);
      check("unstall_y", int'(bus8.y), 0);

      // Saturation and clear-over-increment priority.
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b1, 8'h00, 1'b1, 1'b0);
      check("sat_err2", int'(bus2.err_count), 3);
      check("sat_err8", int'(bus8.err_count), 5);
      cycle(1'b1, 8'h00, 1'b1, 1'b1);
      check("clr_prio_err2", int'(bus2.err_count), 0);
      check("clr_prio_err8", int'(bus8.err_count), 0);
      check("clr_datapath", int'(bus8.none), 1);

      // Asynchronous reset between edges while a result is held.
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h40, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("async_out_valid", int'(bus8.out_valid), 0);
      check("async_err8", int'(bus8.err_count), 0);
      check("async_err2", int'(bus2.err_count), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0:       ra = 8'h00;
            1, 2:    ra = 8'(1 << $urandom_range(0, 7));
            default: ra = 8'($urandom);
         endcase
         cycle(($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/onehot_encoder_reg.md
Name: onehot_encoder_reg

Overview:
Registered 2^N-to-N priority encoder. It is the inverse of the N-to-2^N decoder: it takes a 2^N-bit word, which is normally one-hot, and returns the binary index of its highest set bit. Input and output use valid/ready handshakes with a single-entry output register. The block flags words that are zero or have more than one bit set, and keeps a saturating count of such errors.

Parameters:
N, 3, index width; input word width is 2^N.
ERRW, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  a holds a word to encode
in_ready  output  1  block can accept a word this cycle
a  input  2^N  input word
out_valid  output  1  y/flags hold a result
out_ready  input  1  consumer accepts the result
y  output  N  index of highest set bit of the accepted word
multi  output  1  accepted word had ≥2 bits set
none  output  1  accepted word was all zeros
err_count  output  ERRW  accepted words with multi or none set, saturating
clr_err  input  1  synchronous clear of err_count

Behaviour:
- Reset (async assert, released on clk): out_valid=0, y=0, multi=0, none=0, err_count=0.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Accept when in_valid && in_ready. On that edge:
  - y <= index of highest set bit of a.
  - multi <= (popcount(a) ≥ 2).
  - none <= (a == 0), with y <= 0 in that case.
  - out_valid <= 1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid <= 0. y and flags hold their last values.
- Stall: out_valid && !out_ready -> y, multi, none, out_valid hold. in_ready=0, and a is ignored.
- Simultaneous drain and accept: the new result replaces the old one on the same edge, out_valid stays 1, and no bubble is inserted.
- Error counter:
  - Increments by 1 on each accept where multi or none is computed true.
  - Saturates at 2^ERRW−1, with no wrap.
  - clr_err has priority over an increment in the same cycle; the result is 0.
  - clr_err does not affect the data path.
- Reset asserted mid-stream: the held result is discarded immediately (out_valid=0) and err_count=0. No accept happens on the edge where reset is released.
- y is valid only while out_valid=1. The consumer must not sample it otherwise.

Test Plan:
1. Reset with in_valid=1, a=8'b0000_0100 -> out_valid=0, err_count=0 while reset is high. Then release reset with out_ready=1 -> next cycle y=3'd2, multi=0, none=0, out_valid=1.
2. Sweep all 8 one-hot inputs back-to-back with out_ready=1 -> y=0..7 on consecutive cycles, out_valid held at 1, err_count=0. Each output must match the decoder module's inverse (decode(y)==a).
3. Apply a=8'b1010_0000 -> y=7, multi=1. Then apply a=8'h00 -> y=0, none=1. Check err_count=2 after both.
4. Backpressure: accept a=8'h10, then hold out_ready=0 for 3 cycles while presenting a=8'h01 -> y stays 4 and in_ready=0. Raise out_ready -> 8'h01 is accepted on that same edge and y=0 the following cycle with no bubble.
5. Saturation with ERRW=2: apply 5 zero words -> err_count=3. Then assert clr_err together with another zero-word accept -> err_count=0.
6. Assert reset asynchronously between edges while out_valid=1 -> out_valid drops before the next clk edge, and err_count=0.
